right_shifter_seq: RTL and testbench
====================================

// Module: right_shifter_seq
// PURPOSE
//  Multi-cycle right shifter for the ALU: logical or arithmetic shift of in_a by 'shift' places,
//  one bit per clock, with a start/done handshake. Complements the combinational left shifter.
//  Returns the same flags_n_z_v_c nibble layout as every other ALU unit, so flag muxing is uniform.
// PARAMETERS
//  size  16  datapath width in bits
//  m     4   width of shift amount; legal shifts 0..2^m-1 (intended 0..size-1)
// PORTS
//  clk            in   1     clock; all state updates on rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  start          in   1     request; sampled only while busy==0
//  in_a           in   size  operand, captured on accepted start
//  shift          in   m     shift amount, captured on accepted start
//  arith          in   1     1 = arithmetic (sign fill), 0 = logical (zero fill); captured on start
//  busy           out  1     high from the cycle after accept until done is asserted
//  done           out  1     one-cycle pulse; out and flags are valid from this cycle
//  out            out  size  shifted result, held until the next done
//  flags_n_z_v_c  out  4     [3]=N, [2]=Z, [1]=V, [0]=C; held until the next done
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; busy=0, done=0, out=0, flags_n_z_v_c=4'b0000, count=0.
//   Reset mid-operation aborts the shift; no done is produced.
//  FSM states: IDLE, SHIFT, DONE (registered).
//   IDLE: start=1 loads acc<=in_a, cnt<=shift, mode<=arith, cy<=0.
//         Next state is SHIFT if shift!=0, else DONE.
//   SHIFT: busy=1. Each cycle: cy<=acc[0]; acc<={fill,acc[size-1:1]}, where fill=mode?acc[size-1]:0;
//          cnt<=cnt-1. When cnt==1, this is the last shift; next state is DONE.
//   DONE: done=1, busy=0 for exactly one cycle. out<=acc and flags are registered on entry.
//         Next state is IDLE. A start seen while in DONE is ignored.
//  Latency: a start accepted at edge E0 makes done visible after edge E(shift); that is shift+1 cycles.
//  start while busy or done is high is ignored; there is no queuing and captured operands are unaffected.
//  in_a/shift/arith may change freely after the accept edge.
//  Flags, computed on the final result:
//   N = out[size-1]
//   Z = ~|out
//   V = 0 always
//   C = last bit shifted out (in_a[shift-1]); C=0 when shift==0
//  Shift >= size: logical gives out=0; arithmetic gives all sign bits. C follows the bit-serial rule:
//   0 for logical, sign bit for arithmetic once shift > size.
//  out/flags change only on DONE entry (or reset); they are stable between operations.
//  Back-to-back ops: the earliest next accept is in IDLE, i.e. the cycle after done.
// TESTING
//  T1 logical: in_a=16'hF00F, shift=4, arith=0 -> out=16'h0F00, flags=4'b0001 (C=1); done 5 cycles after start edge.
//  T2 arithmetic: in_a=16'h8001, shift=1, arith=1 -> out=16'hC000, flags=4'b1001 (N=1, C=1); done after 2 cycles.
//  T3 zero shift: in_a=16'h0000, shift=0 -> out=16'h0000, flags=4'b0100 (Z=1, C=0); done 1 cycle after start, busy never high.
//  T4 max shift logical: in_a=16'h8000, shift=15 -> out=16'h0001, flags=4'b0000 (C=in_a[14]=0); busy high 15 cycles.
//   Then with arith=1 -> out=16'hFFFF, flags=4'b1000.
//  T5 start while busy: during T4 pulse start with in_a=16'h1234, shift=2 -> ignored.
//   T4 result unchanged; exactly one done pulse.
//  T6 reset mid-op: assert rst_n=0 at SHIFT cycle 3 of T1 -> out=0, flags=0, busy=0 immediately.
//   No done pulse; a fresh start after release completes normally.

Source files
------------

// File: rtl/right_shifter_seq.sv
// Bit-serial right shifter (logical/arithmetic) with start/done handshake.
// Result and N/Z/V/C flags are registered when the DONE state is entered and held until the next op.
module right_shifter_seq #(
   parameter int size = 16,
   parameter int m    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [size-1:0] in_a,
   input  logic [m-1:0]    shift,
   input  logic            arith,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] out,
   output logic [3:0]      flags_n_z_v_c
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state, state_next;
   logic [size-1:0] acc, acc_next;
   logic [m-1:0]    cnt, cnt_next;
   logic            mode, mode_next;
   logic            cy, cy_next;

   // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
   always_comb begin
      state_next = state;
      acc_next   = acc;
      cnt_next   = cnt;
      mode_next  = mode;
      cy_next    = cy;
      unique case (state)
         IDLE: begin
            if (start) begin
               acc_next   = in_a;
               cnt_next   = shift;
               mode_next  = arith;
               cy_next    = 1'b0;
               state_next = (shift != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            cy_next  = acc[0];
            acc_next = {mode & acc[size-1], acc[size-1:1]};
            cnt_next = cnt - 1'b1;
            if (cnt == m'(1)) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         mode          <= 1'b0;
         cy            <= 1'b0;
         out           <= '0;
         flags_n_z_v_c <= 4'b0000;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         cnt   <= cnt_next;
         mode  <= mode_next;
         cy    <= cy_next;
         // Capture the post-shift value on the edge that enters DONE, so done and out align.
         if (state_next == DONE) begin
            out           <= acc_next;
            flags_n_z_v_c <= {acc_next[size-1], ~|acc_next, 1'b0, cy_next};
         end
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_right_shifter_seq.sv
// Self-checking bench for right_shifter_seq: directed corner cases plus randomized ops
// compared against an arithmetic reference model (>> / >>> and direct bit pick for C).
module tb_right_shifter_seq;
   localparam int size = 16;
   localparam int m    = 4;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic [size-1:0] in_a  = '0;
   logic [m-1:0]    shift = '0;
   logic            arith = 1'b0;
   logic            busy, done;
   logic [size-1:0] out;
   logic [3:0]      flags_n_z_v_c;

   int total = 0;
   int bad   = 0;
   logic [size-1:0] last_out   = '0;
   logic [3:0]      last_flags = '0;

   always #5 clk = ~clk;

   right_shifter_seq #(.size(size), .m(m)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .shift(shift), .arith(arith),
      .busy(busy), .done(done), .out(out), .flags_n_z_v_c(flags_n_z_v_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [size-1:0] a, input logic [m-1:0] s, input logic ar,
                         input bit poke, input string tag);
      logic [size-1:0] eo;
      logic [3:0]      ef;
      int k, nbusy;
      bit seen;
      eo = ar ? size'($signed(a) >>> s) : (a >> s);
      ef = {eo[size-1], (eo == '0), 1'b0, (s == 0) ? 1'b0 : a[s-1]};

      @(negedge clk);
      start = 1'b1; in_a = a; shift = s; arith = ar;
      @(posedge clk); #1;
      start = 1'b0; in_a = size'($urandom); shift = m'($urandom); arith = 1'($urandom);
      k = 0; nbusy = 0; seen = 0;
      while (!seen && k <= 40) begin
         if (done) seen = 1;
         else begin
            if (busy) nbusy++;
            if (k == 1) check({tag, "_hold"}, {out, flags_n_z_v_c}, {last_out, last_flags});
            start = (poke && k == 2) ? 1'b1 : ($urandom_range(0, 3) == 0);
            in_a  = poke ? 16'h1234 : size'($urandom);
            shift = poke ? 4'd2 : m'($urandom);
            @(posedge clk); #1;
            k++;
         end
      end
      check({tag, "_seen"}, seen, 1'b1);
      check({tag, "_lat"}, k, s);
      check({tag, "_busy_cycles"}, nbusy, s);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_out"}, out, eo);
      check({tag, "_flags"}, flags_n_z_v_c, ef);

      // A start presented during DONE must be ignored.
      start = 1'b1; in_a = size'($urandom); shift = m'($urandom); arith = 1'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_pulse"}, {busy, done}, 2'b00);
      @(posedge clk); #1;
      check({tag, "_idle"}, {busy, done, out, flags_n_z_v_c}, {2'b00, eo, ef});
      last_out = eo; last_flags = ef;
   endtask

   initial begin
      bit any_done;

      #2 rst_n = 1'b0;
      #10;
      check("reset", {busy, done, out, flags_n_z_v_c}, {2'b00, 16'h0000, 4'b0000});
      @(negedge clk) rst_n = 1'b1;

      run_op(16'hF00F, 4'd4,  1'b0, 1'b0, "t1_logical");
      run_op(16'h8001, 4'd1,  1'b1, 1'b0, "t2_arith");
      run_op(16'h0000, 4'd0,  1'b0, 1'b0, "t3_zero");
      run_op(16'h8000, 4'd15, 1'b0, 1'b1, "t4_max_log_poke");
      run_op(16'h8000, 4'd15, 1'b1, 1'b0, "t4_max_arith");

      // Reset during SHIFT cycle 3 of the T1 operation.
      @(negedge clk);
      start = 1'b1; in_a = 16'hF00F; shift = 4'd4; arith = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t6_reset_mid", {busy, done, out, flags_n_z_v_c}, {2'b00, 16'h0000, 4'b0000});
      @(negedge clk) rst_n = 1'b1;
      any_done = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done || busy) any_done = 1;
      end
      check("t6_no_done", any_done, 1'b0);
      last_out = '0; last_flags = '0;
      run_op(16'hF00F, 4'd4, 1'b0, 1'b0, "t6_restart");

      for (int i = 0; i < 40; i++)
         run_op(size'($urandom), m'($urandom), 1'($urandom), 1'b0, "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
